// File: rtl/jk_bank_pkg.sv
// jk_bank_pkg: op encodings, FSM state type and default bank width shared by the JK bank arbiter.
package jk_bank_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] CLR  = 2'b01;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] TGL  = 2'b11;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
endpackage

// File: rtl/jk_cell.sv
// jk_cell: one JK storage bit with asynchronous active-low reset to 0.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);
  logic q_q, q_d;
  assign q_d = j_i ? (k_i ? ~q_q : 1'b1) : (k_i ? 1'b0 : q_q);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q_q <= 1'b0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/jk_bank_arb.sv
// jk_bank_arb: two-requester arbiter driving a bank of JK bits through an IDLE/EXEC/DONE handshake.
// Define JK_BANK_ARB_FIXED_PRI_EN to give A fixed priority instead of round-robin.
module jk_bank_arb
  import jk_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [1:0]       op_a,
  input  logic [1:0]       op_b,
  input  logic [WIDTH-1:0] mask_a,
  input  logic [WIDTH-1:0] mask_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done,
  output logic             done_id,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic id_q, id_d;
  logic start, exec, win_b;
  assign start = (state_q == IDLE) && (req_a || req_b);
  assign exec  = state_q == EXEC;
`ifdef JK_BANK_ARB_FIXED_PRI_EN
  assign win_b = req_b && !req_a;
`else
  logic last_q, last_d;
  // last_q=1 means B was granted last, so A wins the next tie
  assign win_b  = req_b && (!req_a || !last_q);
  assign last_d = start ? win_b : last_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_q <= 1'b1;
    else last_q <= last_d;
`endif
  always_comb begin
    state_d = start ? EXEC : exec ? DONE : IDLE;
    op_d    = start ? (win_b ? op_b : op_a) : op_q;
    mask_d  = start ? (win_b ? mask_b : mask_a) : mask_q;
    id_d    = start ? win_b : id_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= HOLD;
      mask_q  <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      id_q    <= id_d;
    end
  assign gnt_a   = exec && !id_q;
  assign gnt_b   = exec && id_q;
  assign done    = state_q == DONE;
  assign done_id = done && id_q;
  assign busy    = state_q != IDLE;
  assign qb      = ~q;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j_i (exec && mask_q[i] && op_q[1]),
      .k_i (exec && mask_q[i] && op_q[0]),
      .q_o (q[i])
    );
  end
endmodule

// File: tb/tb_jk_bank_arb.sv
// tb_jk_bank_arb: directed self-checking bench for jk_bank_arb.
module tb_jk_bank_arb;
  import jk_bank_pkg::*;
  logic clk = 1'b0;
  logic rst, req_a, req_b;
  logic [1:0] op_a, op_b;
  logic [7:0] mask_a, mask_b, q, qb;
  logic gnt_a, gnt_b, done, done_id, busy;
  int n_tests = 0;
  int n_fail = 0;

  jk_bank_arb #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .mask_a(mask_a), .mask_b(mask_b), .gnt_a(gnt_a), .gnt_b(gnt_b), .done(done),
    .done_id(done_id), .busy(busy), .q(q), .qb(qb)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input bit b, input logic [1:0] op, input logic [7:0] mask,
                        input logic [7:0] exp_q);
    req_a = !b; req_b = b;
    op_a = op; op_b = op; mask_a = mask; mask_b = mask;
    tick;
    chk("gnt_a_exec", {31'd0, gnt_a}, {31'd0, !b});
    chk("gnt_b_exec", {31'd0, gnt_b}, {31'd0, b});
    chk("busy_exec", {31'd0, busy}, 32'd1);
    chk("done_exec", {31'd0, done}, 32'd0);
    req_a = 1'b0; req_b = 1'b0;
    tick;
    chk("q_done", {24'd0, q}, {24'd0, exp_q});
    chk("qb_done", {24'd0, qb}, {24'd0, ~exp_q});
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_id", {31'd0, done_id}, {31'd0, b});
    chk("gnt_off", {30'd0, gnt_a, gnt_b}, 32'd0);
    tick;
    chk("done_end", {31'd0, done}, 32'd0);
    chk("busy_end", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [3:0] exp_gnt_seq;
    logic [7:0] exp_rr_q;
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    op_a = HOLD; op_b = HOLD; mask_a = 8'h00; mask_b = 8'h00;
    #1 rst = 1'b0;
    tick;
    tick;
    chk("rst_q", {24'd0, q}, 32'h00);
    chk("rst_qb", {24'd0, qb}, 32'hFF);
    chk("rst_gnt", {30'd0, gnt_a, gnt_b}, 32'd0);
    chk("rst_done", {30'd0, done, done_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    tick;
    do_cmd(1'b0, SET, 8'h0F, 8'h0F);
    do_cmd(1'b1, TGL, 8'hFF, 8'hF0);
    do_cmd(1'b0, CLR, 8'hFF, 8'h00);
    do_cmd(1'b1, SET, 8'hAA, 8'hAA);
    do_cmd(1'b0, CLR, 8'h00, 8'hAA);
    do_cmd(1'b1, HOLD, 8'hFF, 8'hAA);
    // request withdrawn before any edge samples it
    req_a = 1'b1; op_a = TGL; mask_a = 8'hFF;
    #3 req_a = 1'b0;
    tick;
    chk("short_req_gnt", {30'd0, gnt_a, gnt_b}, 32'd0);
    chk("short_req_busy", {31'd0, busy}, 32'd0);
    tick;
    chk("short_req_q", {24'd0, q}, 32'hAA);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    chk("rst2_q", {24'd0, q}, 32'h00);
`ifdef JK_BANK_ARB_FIXED_PRI_EN
    exp_gnt_seq = 4'b0000;
    exp_rr_q = 8'h01;
`else
    exp_gnt_seq = 4'b1010;
    exp_rr_q = 8'h03;
`endif
    req_a = 1'b1; req_b = 1'b1;
    op_a = SET; op_b = SET; mask_a = 8'h01; mask_b = 8'h02;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("rr_gnt_b_%0d", i), {31'd0, gnt_b}, {31'd0, exp_gnt_seq[i]});
      chk($sformatf("rr_gnt_a_%0d", i), {31'd0, gnt_a}, {31'd0, !exp_gnt_seq[i]});
      if (i == 3) begin
        req_a = 1'b0; req_b = 1'b0;
      end
      tick;
      tick;
    end
    chk("rr_q", {24'd0, q}, {24'd0, exp_rr_q});
    req_a = 1'b1; op_a = SET; mask_a = 8'hFF;
    tick;
    chk("abort_gnt", {31'd0, gnt_a}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_q", {24'd0, q}, 32'h00);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_gnt_off", {30'd0, gnt_a, gnt_b}, 32'd0);
    req_a = 1'b0;
    tick;
    chk("abort_done_rst", {31'd0, done}, 32'd0);
    rst = 1'b1;
    tick;
    chk("abort_done_after", {31'd0, done}, 32'd0);
    chk("abort_q_after", {24'd0, q}, 32'h00);
    do_cmd(1'b1, SET, 8'h3C, 8'h3C);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/jk_bank_arb.md
JK_BANK_ARB -- requirements
Module: jk_bank_arb

Interface
REQ-001 Parameter WIDTH, default 8, number of JK storage bits in the bank.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 req_a / req_b  input  1 each  command request from requester A / B, held high until granted.
REQ-005 op_a / op_b  input  2 each  command: 00 hold, 01 clear, 10 set, 11 toggle; stable while req high.
REQ-006 mask_a / mask_b  input  WIDTH each  bit-select for the command; stable while req high.
REQ-007 gnt_a / gnt_b  output  1 each  one-cycle grant pulse, never both high.
REQ-008 done  output  1  one-cycle pulse when the bank update completes.
REQ-009 done_id  output  1  requester of the completed command (0=A, 1=B), valid when done=1.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 q  output  WIDTH  bank contents; qb  output  WIDTH  bitwise complement of q.

Function
REQ-012 FSM states IDLE, EXEC, DONE; IDLE->EXEC on any sampled req; EXEC->DONE unconditionally; DONE->IDLE unconditionally.
REQ-013 On IDLE->EXEC, latch winner's op, mask, and id; assert that requester's gnt for the EXEC cycle only.
REQ-014 In EXEC, per bit i: mask[i]=0 gives j=0,k=0; mask[i]=1 gives j/k = op[1]/op[0].
REQ-015 The bank updates on the EXEC->DONE edge: 00 hold, 01 q=0, 10 q=1, 11 q=~q, per masked bit.
REQ-016 done and done_id assert for the DONE cycle only.
REQ-017 Latency: req sampled at edge N -> gnt during N..N+1 -> q updated at N+1 -> done during N+1..N+2 -> IDLE at N+2; one command per 3 cycles max.
REQ-018 Requests are ignored in EXEC and DONE; a req still high in IDLE counts as a new request.
REQ-019 Round-robin arbitration: on simultaneous req_a and req_b, grant the requester not granted last; a single requester always wins.
REQ-020 mask=0 or op=00 still completes the full handshake with q unchanged.
REQ-021 A req deasserted before being sampled in IDLE produces no grant and no q change.

Reset
REQ-022 Asserting rst forces q=0, qb all ones, state IDLE, gnt_a=gnt_b=0, done=0, done_id=0, busy=0, and the last-grant pointer to B, so A wins the first tie.
REQ-023 rst asserted in EXEC or DONE aborts the command: no q update and no done pulse; after release, operation resumes from IDLE.
REQ-024 q never takes X or Z values after reset.

Configuration
REQ-025 Macro JK_BANK_ARB_FIXED_PRI_EN defined: A always wins simultaneous requests, and the last-grant pointer is not implemented.
REQ-026 Macro JK_BANK_ARB_FIXED_PRI_EN undefined: round-robin per REQ-019.

Structure
REQ-027 Package jk_bank_pkg holds the op encoding constants (HOLD, CLR, SET, TGL), the FSM state typedef, and the default WIDTH.
REQ-028 Sub-module jk_cell is instantiated WIDTH times; each is one JK bit with async active-low reset to 0.

Verification
REQ-029 Reset, then req_a=1, op_a=10, mask_a=8'h0F -> gnt_a pulses one cycle, q=8'h0F one cycle later, done=1 with done_id=0.
REQ-030 From q=8'h0F, req_b=1, op_b=11, mask_b=8'hFF -> gnt_b pulses, q=8'hF0, done_id=1.
REQ-031 req_a and req_b both held high for 4 commands after reset -> grants in order A,B,A,B; with JK_BANK_ARB_FIXED_PRI_EN defined -> A,A,A,A.
REQ-032 op=01, mask=8'h00 with q=8'hAA -> full gnt/done handshake, q stays 8'hAA.
REQ-033 rst pulsed low during EXEC of a set command with mask 8'hFF -> q=8'h00, no done pulse, busy=0, next request serviced normally.
